// File: rtl/axicb_wr_arbiter_switch.sv
// Write-path switch stage: routes one of REQ_NB AW channels to the master port via an external
// round-robin grant, and queues granted indices so W bursts follow AW order.
module axicb_wr_arbiter_switch #(
    parameter int REQ_NB     = 4,
    parameter int AWCH_W     = 64,
    parameter int WCH_W      = 40,
    parameter int OSTDREQ_NB = 4
) (
    input  logic                     aclk,
    input  logic                     srst,
    input  logic [REQ_NB-1:0]        i_awvalid,
    output logic [REQ_NB-1:0]        i_awready,
    input  logic [REQ_NB*AWCH_W-1:0] i_awch,
    input  logic [REQ_NB-1:0]        i_wvalid,
    output logic [REQ_NB-1:0]        i_wready,
    input  logic [REQ_NB-1:0]        i_wlast,
    input  logic [REQ_NB*WCH_W-1:0]  i_wch,
    output logic                     o_awvalid,
    input  logic                     o_awready,
    output logic [AWCH_W-1:0]        o_awch,
    output logic                     o_wvalid,
    input  logic                     o_wready,
    output logic                     o_wlast,
    output logic [WCH_W-1:0]         o_wch,
    output logic                     rr_en,
    output logic [REQ_NB-1:0]        rr_req,
    input  logic [REQ_NB-1:0]        rr_grant
);

    localparam int PTR_W = $clog2(OSTDREQ_NB);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OSTDREQ_NB);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [REQ_NB-1:0]  awsel_q, awsel_d;
    logic [REQ_NB-1:0]  fifo_q [OSTDREQ_NB];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push, pop;
    logic               fifo_full, fifo_empty;
    logic [REQ_NB-1:0]  head;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // AW arbitration and routing
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d   = state_q;
        awsel_d   = awsel_q;
        rr_en     = 1'b0;
        rr_req    = '0;
        o_awvalid = 1'b0;
        i_awready = '0;
        push      = 1'b0;
        o_awch    = '0;
        for (int k = 0; k < REQ_NB; k++) begin
            o_awch = o_awch | (i_awch[k*AWCH_W +: AWCH_W] & {AWCH_W{awsel_q[k]}});
        end
        case (state_q)
            IDLE: begin
                rr_en  = 1'b1;
                rr_req = fifo_full ? '0 : i_awvalid;
                if (|rr_grant) begin
                    awsel_d = rr_grant;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                o_awvalid = |(i_awvalid & awsel_q);
                i_awready = awsel_q & {REQ_NB{o_awready}};
                if (o_awvalid && o_awready) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (srst) begin
            state_q <= IDLE;
            awsel_q <= '0;
        end else begin
            state_q <= state_d;
            awsel_q <= awsel_d;
        end
    end

    // Write-order FIFO control: push only ever happens with a free slot reserved at grant time
    always_ff @(posedge aclk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: FIFO storage is left unreset; the count gates every read, so stale entries are never used.
    always_ff @(posedge aclk) begin
        if (push) fifo_q[wr_ptr_q] <= awsel_q;
    end

    // W routing steered by the oldest outstanding AW
    always_comb begin
        o_wvalid = 1'b0;
        o_wlast  = 1'b0;
        o_wch    = '0;
        i_wready = '0;
        if (!fifo_empty) begin
            for (int k = 0; k < REQ_NB; k++) begin
                o_wch   = o_wch | (i_wch[k*WCH_W +: WCH_W] & {WCH_W{head[k]}});
                o_wlast = o_wlast | (i_wlast[k] & head[k]);
            end
            o_wvalid = |(i_wvalid & head);
            i_wready = head & {REQ_NB{o_wready}};
        end
    end

    assign pop = o_wvalid & o_wready & o_wlast;

endmodule
